pwm_ramp_generator: RTL and testbench

Consumes the per-state `base_duty` / `ramp_enable` pair from the PWM state lookup stage and produces the physical PWM waveform.
- Runs a free-running period counter.
- Either steps the active duty straight to the target or slews it toward the target by a fixed increment once per PWM period.
- Duty changes take effect only at period boundaries, so output pulses are never truncated or glitched.
- Sits between the state lookup and the motor/LED driver pin.

---
 rtl/pwm_pkg.sv | 10 +
 rtl/pwm_period_counter.sv | 28 ++
 rtl/pwm_ramp_generator.sv | 80 ++++++++
 tb/tb_pwm_ramp_generator.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: default period/width/step and the ramp FSM state type.
package pwm_pkg;
    localparam int PWM_PERIOD    = 1200;
    localparam int PWM_DUTY_W    = 12;
    localparam int PWM_RAMP_STEP = 12;

    typedef logic [PWM_DUTY_W-1:0] duty_t;

    typedef enum logic {IDLE, RUN} pwm_ramp_state_t;
endpackage

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter with a one-cycle tick on the last count.
module pwm_period_counter
    import pwm_pkg::*;
#(
    parameter int PERIOD = PWM_PERIOD,
    parameter int CNT_W  = PWM_DUTY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             active,
    output logic [CNT_W-1:0] cnt,
    output logic             period_tick
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    // Held at zero while inactive so a restart always begins a full period.
    always_ff @(posedge clk) begin
        if (rst || clear || !active)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign period_tick = active && (cnt == LAST);
endmodule

// File: rtl/pwm_ramp_generator.sv
// PWM output stage: duty is stepped or slewed toward the clamped target at period boundaries only.
module pwm_ramp_generator
    import pwm_pkg::*;
#(
    parameter int PERIOD    = PWM_PERIOD,
    parameter int RAMP_STEP = PWM_RAMP_STEP,
    parameter int DUTY_W    = PWM_DUTY_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DUTY_W-1:0] base_duty,
    input  logic              ramp_enable,
    output logic              pwm_out,
    output logic [DUTY_W-1:0] duty_now,
    output logic              period_tick,
    output logic              at_target
);
    localparam logic [DUTY_W-1:0] FULL   = DUTY_W'(PERIOD);
    localparam logic [DUTY_W:0]   STEP_X = (DUTY_W+1)'(RAMP_STEP);

    pwm_ramp_state_t   state, state_d;
    logic [DUTY_W-1:0] cnt, tgt, duty_step, duty_d;
    logic [DUTY_W:0]   up_x, gap_x;
    logic              pwm_d, at_d;

    pwm_period_counter #(.PERIOD(PERIOD), .CNT_W(DUTY_W)) u_period (
        .clk         (clk),
        .rst         (rst),
        .clear       (!enable),
        .active      (state == RUN),
        .cnt         (cnt),
        .period_tick (period_tick)
    );

    assign tgt   = (base_duty > FULL) ? FULL : base_duty;
    assign up_x  = {1'b0, duty_now} + STEP_X;
    assign gap_x = {1'b0, duty_now} - {1'b0, tgt};

    // Extra bit on both slews lands exactly on the target instead of wrapping.
    always_comb begin
        duty_step = duty_now;
        if (!ramp_enable)
            duty_step = tgt;
        else if (duty_now < tgt)
            duty_step = (up_x >= {1'b0, tgt}) ? tgt : up_x[DUTY_W-1:0];
        else if (duty_now > tgt)
            duty_step = (gap_x <= STEP_X) ? tgt : duty_now - STEP_X[DUTY_W-1:0];
    end

    always_comb begin
        state_d = state;
        duty_d  = duty_now;
        case (state)
            IDLE:    if (enable)  state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!enable || state == IDLE)
            duty_d = '0;
        else if (period_tick)
            duty_d = duty_step;
        pwm_d = enable && (state == RUN) && (cnt < duty_now);
        at_d  = (state == RUN) && (duty_now == tgt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            duty_now  <= '0;
            pwm_out   <= 1'b0;
            at_target <= 1'b0;
        end else begin
            state     <= state_d;
            duty_now  <= duty_d;
            pwm_out   <= pwm_d;
            at_target <= at_d;
        end
    end
endmodule

// File: tb/tb_pwm_ramp_generator.sv
// Scoreboard bench for pwm_ramp_generator; a short period keeps the ramp scenarios brief.
module tb_pwm_ramp_generator;
    localparam int P    = 240;
    localparam int STEP = 12;
    localparam int DW   = 12;

    logic          clk, rst, enable, ramp_enable;
    logic [DW-1:0] base_duty, duty_now;
    logic          pwm_out, period_tick, at_target;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];

    pwm_ramp_generator #(.PERIOD(P), .RAMP_STEP(STEP), .DUTY_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .base_duty   (base_duty),
        .ramp_enable (ramp_enable),
        .pwm_out     (pwm_out),
        .duty_now    (duty_now),
        .period_tick (period_tick),
        .at_target   (at_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < 3*P);
        if (!period_tick) begin
            checks++; errors++;
            $display("FAIL tick_timeout waited %0d cycles, required a period_tick", n);
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1; enable = 0; ramp_enable = 0; base_duty = '0;
        repeat (3) @(negedge clk);
        rst = 0;
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm got %b want 0", pwm_out); end
        checks++; if (duty_now !== '0) begin errors++; $display("FAIL reset_duty got %0d want 0", duty_now); end
        checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", period_tick); end
        checks++; if (at_target !== 1'b0) begin errors++; $display("FAIL reset_at_target got %b want 0", at_target); end
        bad = 0;
        repeat (5000) begin
            @(negedge clk);
            if (pwm_out !== 1'b0 || duty_now !== '0 || period_tick !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_quiet got %0d active cycles want 0", bad); end
    endtask

    task automatic test_step();
        int n, hi;
        logic [DW-1:0] d;
        ramp_enable = 0; base_duty = 120; enable = 1;
        exp_q.push_back(12'd120);
        wait_tick(n);
        checks++; if (n != P) begin errors++; $display("FAIL step_first_tick got %0d want %0d", n, P); end
        checks++; if (duty_now !== '0) begin errors++; $display("FAIL step_pre_tick_duty got %0d want 0", duty_now); end
        @(negedge clk);
        d = exp_q.pop_front();
        checks++; if (duty_now !== d) begin errors++; $display("FAIL step_duty got %0d want %0d", duty_now, d); end
        checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL step_tick_width got %b want 0", period_tick); end
        @(negedge clk);
        checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL step_at_target got %b want 1", at_target); end
        hi = 0;
        repeat (P) begin @(negedge clk); if (pwm_out) hi++; end
        checks++; if (hi != d) begin errors++; $display("FAIL step_width got %0d want %0d", hi, d); end
    endtask

    task automatic test_mid_change();
        int n, hi;
        logic [DW-1:0] d;
        wait_tick(n);
        hi = 0;
        for (int k = 0; k < P; k++) begin
            @(negedge clk);
            if (pwm_out) hi++;
            if (k == P/4) base_duty = 4000;
        end
        checks++; if (period_tick !== 1'b1) begin errors++; $display("FAIL mid_tick_pos got %b want 1", period_tick); end
        checks++; if (duty_now !== 12'd120) begin errors++; $display("FAIL mid_duty_held got %0d want 120", duty_now); end
        checks++; if (hi != 120) begin errors++; $display("FAIL mid_width got %0d want 120", hi); end
        exp_q.push_back(12'(P));
        @(negedge clk);
        d = exp_q.pop_front();
        checks++; if (duty_now !== d) begin errors++; $display("FAIL clamp_duty got %0d want %0d", duty_now, d); end
        hi = 0;
        repeat (2*P) begin @(negedge clk); if (pwm_out) hi++; end
        checks++; if (hi != 2*P) begin errors++; $display("FAIL full_high got %0d want %0d", hi, 2*P); end
        checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL clamp_at_target got %b want 1", at_target); end
    endtask

    task automatic test_ramp_down();
        int n;
        logic [DW-1:0] d, prev;
        ramp_enable = 1; base_duty = 5;
        d = 12'(P);
        while (d != 5) begin
            d = (d > 5 + STEP) ? d - 12'(STEP) : 12'd5;
            exp_q.push_back(d);
        end
        prev = 12'(P);
        while (exp_q.size() > 0) begin
            wait_tick(n);
            checks++; if (at_target !== (prev == 5)) begin errors++; $display("FAIL down_at_target got %b want %b", at_target, prev == 5); end
            @(negedge clk);
            d = exp_q.pop_front();
            checks++; if (duty_now !== d) begin errors++; $display("FAIL down_duty got %0d want %0d", duty_now, d); end
            prev = d;
        end
        wait_tick(n);
        checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL down_final_at got %b want 1", at_target); end
        @(negedge clk);
        checks++; if (duty_now !== 12'd5) begin errors++; $display("FAIL down_hold got %0d want 5", duty_now); end
    endtask

    task automatic test_abort();
        int n, bad;
        logic [DW-1:0] d;
        ramp_enable = 0; base_duty = 120;
        for (int pass = 0; pass < 2; pass++) begin
            exp_q.push_back(12'd120);
            wait_tick(n);
            @(negedge clk);
            d = exp_q.pop_front();
            checks++; if (duty_now !== d) begin errors++; $display("FAIL abort_setup_duty got %0d want %0d", duty_now, d); end
            repeat (40) @(negedge clk);
            checks++; if (pwm_out !== 1'b1) begin errors++; $display("FAIL abort_pre_pwm got %b want 1", pwm_out); end
            if (pass == 0) rst = 1; else enable = 0;
            @(negedge clk);
            checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL abort_pwm got %b want 0", pwm_out); end
            checks++; if (duty_now !== '0) begin errors++; $display("FAIL abort_duty got %0d want 0", duty_now); end
            if (pass == 0) begin
                checks++; if (at_target !== 1'b0) begin errors++; $display("FAIL abort_at_target got %b want 0", at_target); end
                rst = 0;
                wait_tick(n);
                checks++; if (n != P) begin errors++; $display("FAIL abort_restart got %0d want %0d", n, P); end
            end else begin
                bad = 0;
                repeat (P + 10) begin
                    @(negedge clk);
                    if (period_tick !== 1'b0 || pwm_out !== 1'b0 || duty_now !== '0) bad++;
                end
                checks++; if (bad != 0) begin errors++; $display("FAIL disabled_quiet got %0d active cycles want 0", bad); end
            end
        end
    endtask

    task automatic test_ramp_up();
        int n, hi;
        logic [DW-1:0] d, prev;
        ramp_enable = 1; base_duty = 12'(P); enable = 1;
        d = '0;
        while (d != 12'(P)) begin
            d = (d + STEP >= P) ? 12'(P) : d + 12'(STEP);
            exp_q.push_back(d);
        end
        prev = '0;
        while (exp_q.size() > 0) begin
            wait_tick(n);
            checks++; if (at_target !== (prev == 12'(P))) begin errors++; $display("FAIL up_at_target got %b want %b", at_target, prev == 12'(P)); end
            @(negedge clk);
            d = exp_q.pop_front();
            checks++; if (duty_now !== d) begin errors++; $display("FAIL up_duty got %0d want %0d", duty_now, d); end
            prev = d;
        end
        @(negedge clk);
        checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL up_final_at got %b want 1", at_target); end
        hi = 0;
        repeat (2*P) begin @(negedge clk); if (pwm_out) hi++; end
        checks++; if (hi != 2*P) begin errors++; $display("FAIL up_full_high got %0d want %0d", hi, 2*P); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_mid_change();
        test_ramp_down();
        test_abort();
        test_ramp_up();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
